cache_line_data_memory: RTL and testbench
=========================================

// Module: cache_line_data_memory
// PURPOSE
//  Data array of the L1 data cache, second generation: multi-word lines, byte-enabled CPU writes.
//  Runs two burst engines against the cache controller:
//   - line FILL: refill from main memory
//   - line EVICT: write-back of a dirty line
//  Sits between the cache controller FSM and the memory bus. Tag/valid/dirty live in a separate tag array.
// PARAMETERS
//  DATA_W      32  word width in bits; multiple of 8
//  IDX_W       5   line index width; IDX_SIZE = 2**IDX_W lines
//  WORD_OFF_W  2   word-in-line select width; WORDS = 2**WORD_OFF_W words per line
//  localparam BE_W = DATA_W/8; CNT_W = WORD_OFF_W
// PORTS
//  iCLK         in   1           clock; all state changes on rising edge
//  iRST         in   1           synchronous active-high reset
//  idx          in   IDX_W       line index for CPU access; latched at burst start
//  word_off     in   WORD_OFF_W  word within line for CPU access
//  cpu_we       in   1           CPU word write request
//  cpu_be       in   BE_W        byte enables for cpu_we
//  cpu_wdata    in   DATA_W      CPU write data
//  cpu_rdata    out  DATA_W      combinational read of word {idx,word_off}
//  fill_start   in   1           begin line fill into line idx
//  fill_valid   in   1           fill_data is valid this cycle
//  fill_data    in   DATA_W      refill word, delivered in order word 0..WORDS-1
//  fill_done    out  1           one-cycle pulse after the last fill word is written
//  evict_start  in   1           begin write-back read-out of line idx
//  evict_ready  in   1           memory side accepts evict_data this cycle
//  evict_valid  out  1           evict_data is valid
//  evict_data   out  DATA_W      word[cnt] of the latched line
//  evict_last   out  1           evict_valid on word WORDS-1
//  busy         out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, busy=0, fill_done=0, evict_valid=0, evict_last=0.
//   Array contents are NOT cleared; the tag array's valid bits guard them.
//  FSM states: IDLE, FILL, EVICT (2-bit encoding).
//  IDLE:
//   - cpu_we=1: bytes of word {idx,word_off} with cpu_be[i]=1 take cpu_wdata[8i+7:8i]; written on the next edge.
//     Other bytes are unchanged; cpu_be=0 is a no-op.
//   - evict_start=1: latch idx into line_q, cnt<=0, go to EVICT.
//   - else fill_start=1: latch idx into line_q, cnt<=0, go to FILL.
//   - Priority: evict_start > fill_start > cpu_we. Only the winner acts; the others are dropped, not queued.
//  FILL:
//   - Each cycle with fill_valid=1: write fill_data to word {line_q,cnt}, full word, cnt<=cnt+1.
//   - fill_valid=0 stalls; there is no timeout.
//   - On the fill_valid that writes word WORDS-1: cnt wraps to 0, go to IDLE, fill_done=1 in the following cycle only.
//  EVICT:
//   - evict_valid=1 throughout. evict_data = array[{line_q,cnt}] combinationally. evict_last = (cnt==WORDS-1).
//   - On an evict_ready handshake: cnt<=cnt+1. On the last-word handshake: go to IDLE.
//   - evict_valid must stay high and evict_data stable while evict_ready=0.
//  Busy rules:
//   - busy=1 in FILL and EVICT. cpu_we, fill_start and evict_start are ignored while busy (no array change).
//   - Changes to idx during a burst do not affect line_q.
//  Read timing: cpu_rdata is always live and combinational from {idx,word_off}, including during bursts.
//   A word written at edge N reads new data after edge N.
//  iRST mid-burst: returns to IDLE next edge. Words already filled remain written; the remainder is untouched.
//   No fill_done pulse, no evict_last.
//  Simultaneous cpu_we and burst start in IDLE: the burst wins; the CPU write is lost.
//   The controller never issues both at once; the bench checks this rule.
// STRUCTURE
//  Shared header cache_defs.vh:
//   - FSM state localparams (ST_IDLE/ST_FILL/ST_EVICT)
//   - default DATA_W/IDX_W/WORD_OFF_W, shared with the tag array and controller
//  Sub-module cache_word_ram:
//   - IDX_SIZE*WORDS x DATA_W storage, byte-enable write port, async read port
//   - instantiated twice? No: one write port and two read ports (cpu, evict)
//  Top level: FSM, counter, line_q, write-port mux (CPU vs fill).
// TESTING
//  1) Reset then IDLE; cpu_we be=4'b1111 0xDEADBEEF @idx3/w1, then be=4'b0010 data 0x0000AA00
//     -> cpu_rdata @idx3/w1 = 0xDEADAAEF.
//  2) fill_start idx=7; fill_valid in cycles 1,3,4,6 with data 0x10..0x13
//     -> words 0..3 = 0x10..0x13; fill_done one cycle after 0x13; busy 1 until then.
//  3) Line 7 preloaded; evict_start idx=7; evict_ready toggling 1,0,0,1,1,0,1
//     -> four handshakes yield 0x10..0x13 in order; evict_data held while ready=0;
//        evict_last only on 0x13; busy drops after the last handshake.
//  4) During FILL: cpu_we to idx 2 and fill_start/evict_start pulses
//     -> idx 2 unchanged; the fill completes normally; no new burst starts.
//  5) iRST after 2 of 4 fill words -> IDLE next edge, busy=0, no fill_done;
//     words 0..1 new, words 2..3 keep old values.
//  6) evict_start and fill_start in the same cycle -> EVICT taken; line unchanged;
//     WORD_OFF_W=3, DATA_W=64 build passes tests 2-3 with 8-word bursts.

Source files
------------

// File: rtl/cache_line_data_memory_pkg.sv
// Shared types and defaults for the L1 data cache data array.
// The tag array and cache controller use the same defaults.
package cache_line_data_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_IDX_W      = 5;
    localparam int DEF_WORD_OFF_W = 2;

endpackage

// File: rtl/cache_line_data_memory_word_ram.sv
// Word storage for the data array: one byte-enabled write port,
// two asynchronous read ports (CPU side and evict side).
module cache_line_data_memory_word_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [DATA_W/8-1:0]    i_be,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0]      i_raddr_a,
    output logic [DATA_W-1:0]      o_rdata_a,
    input  logic [ADDR_W-1:0]      i_raddr_b,
    output logic [DATA_W-1:0]      o_rdata_b
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Byte-lane write; contents are never cleared, tag valid bits guard them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cache_line_data_memory.sv
// L1 data cache data array with line fill and line evict burst engines.
// Sits between the cache controller FSM and the memory bus.
module cache_line_data_memory
    import cache_line_data_memory_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int WORD_OFF_W = DEF_WORD_OFF_W
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WORD_OFF_W-1:0]   word_off,
    input  logic                    cpu_we,
    input  logic [DATA_W/8-1:0]     cpu_be,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    input  logic                    fill_start,
    input  logic                    fill_valid,
    input  logic [DATA_W-1:0]       fill_data,
    output logic                    fill_done,
    input  logic                    evict_start,
    input  logic                    evict_ready,
    output logic                    evict_valid,
    output logic [DATA_W-1:0]       evict_data,
    output logic                    evict_last,
    output logic                    busy
);

    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = WORD_OFF_W;
    localparam int WORDS  = 2 ** WORD_OFF_W;
    localparam int ADDR_W = IDX_W + WORD_OFF_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_line_q;
    logic               r_fill_done;

    logic               w_start;
    logic               w_cpu_wr;
    logic               w_fill_wr;
    logic               w_evict_hs;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_wdata;

    assign w_start    = (r_state == ST_IDLE) && (evict_start || fill_start);
    assign w_cpu_wr   = (r_state == ST_IDLE) && cpu_we && !evict_start && !fill_start;
    assign w_fill_wr  = (r_state == ST_FILL) && fill_valid;
    assign w_evict_hs = (r_state == ST_EVICT) && evict_ready;

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: evict beats fill; bursts end on the last word.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (evict_start) begin
                    w_next = ST_EVICT;
                end else if (fill_start) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_valid && r_cnt == LAST) begin
                    w_next = ST_IDLE;
                end
            end
            ST_EVICT: begin
                if (evict_ready && r_cnt == LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and word counter.
    always_comb begin
        busy        = (r_state != ST_IDLE);
        evict_valid = (r_state == ST_EVICT);
        evict_last  = (r_state == ST_EVICT) && (r_cnt == LAST);
    end

    // Word counter and one-cycle fill completion pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cnt       <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= w_fill_wr && (r_cnt == LAST);
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_fill_wr || w_evict_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Line index captured at burst start, held for the whole burst.
    always_ff @(posedge iCLK) begin
        if (w_start) begin
            r_line_q <= idx;
        end
    end

    assign fill_done = r_fill_done;

    // Write-port mux: fill writes full words, CPU writes by byte lane.
    always_comb begin
        w_we    = !iRST && (w_cpu_wr || w_fill_wr);
        w_waddr = {idx, word_off};
        w_be    = cpu_be;
        w_wdata = cpu_wdata;
        if (w_fill_wr) begin
            w_waddr = {r_line_q, r_cnt};
            w_be    = '1;
            w_wdata = fill_data;
        end
    end

    cache_line_data_memory_word_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (iCLK),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_be      (w_be),
        .i_wdata   (w_wdata),
        .i_raddr_a ({idx, word_off}),
        .o_rdata_a (cpu_rdata),
        .i_raddr_b ({r_line_q, r_cnt}),
        .o_rdata_b (evict_data)
    );

endmodule

// File: tb/tb_cache_line_data_memory.sv
// Scoreboard bench for cache_line_data_memory.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_cache_line_data_memory;

    localparam int DW    = 32;
    localparam int IW    = 5;
    localparam int OW    = 2;
    localparam int BW    = DW / 8;
    localparam int WORDS = 2 ** OW;
    localparam int LINES = 2 ** IW;
    localparam int NW    = LINES * WORDS;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [IW-1:0] idx;
    logic [OW-1:0] word_off;
    logic          cpu_we;
    logic [BW-1:0] cpu_be;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          fill_start;
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic          fill_done;
    logic          evict_start;
    logic          evict_ready;
    logic          evict_valid;
    logic [DW-1:0] evict_data;
    logic          evict_last;
    logic          busy;

    cache_line_data_memory #(
        .DATA_W     (DW),
        .IDX_W      (IW),
        .WORD_OFF_W (OW)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .idx         (idx),
        .word_off    (word_off),
        .cpu_we      (cpu_we),
        .cpu_be      (cpu_be),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .fill_start  (fill_start),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_done   (fill_done),
        .evict_start (evict_start),
        .evict_ready (evict_ready),
        .evict_valid (evict_valid),
        .evict_data  (evict_data),
        .evict_last  (evict_last),
        .busy        (busy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } ev_t;

    logic [DW-1:0] m [NW];
    ev_t           ev_q [$];
    logic [DW-1:0] rd_q [$];
    int            done_q [$];
    bit            pat [$];
    logic [DW-1:0] dq [$];
    int            m_mode = 0;
    bit            mon_en = 0;
    bit            rd_req = 0;
    int            total = 0;
    int            bad = 0;

    task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge iCLK) begin
        if (mon_en) begin
            check("busy", busy, m_mode != 0);
            check("evict_valid", evict_valid, m_mode == 2);
            if (rd_req && rd_q.size() > 0)
                check("cpu_rdata", cpu_rdata, rd_q.pop_front());
            if (fill_done) begin
                if (done_q.size() == 0)
                    check("fill_done_unexp", fill_done, 0);
                else
                    void'(done_q.pop_front());
            end
            if (evict_valid) begin
                if (ev_q.size() == 0) begin
                    check("evict_unexp", evict_valid, 0);
                end else begin
                    check("evict_data", evict_data, ev_q[0].d);
                    check("evict_last", evict_last, ev_q[0].last);
                    if (evict_ready) void'(ev_q.pop_front());
                end
            end else begin
                check("evict_last_idle", evict_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic cpu_write(int l, int o, logic [BW-1:0] be, logic [DW-1:0] d);
        idx = IW'(l);
        word_off = OW'(o);
        cpu_be = be;
        cpu_wdata = d;
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        for (int i = 0; i < BW; i++)
            if (be[i]) m[l*WORDS+o][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic cpu_read(int l, int o);
        idx = IW'(l);
        word_off = OW'(o);
        rd_q.push_back(m[l*WORDS+o]);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_line(int l);
        for (int w = 0; w < WORDS; w++) cpu_read(l, w);
    endtask

    task automatic rand_read();
        int l, o;
        l = $urandom_range(0, LINES - 1);
        o = $urandom_range(0, WORDS - 1);
        idx = IW'(l);
        word_off = OW'(o);
        rd_q.push_back(m[l*WORDS+o]);
        rd_req = 1'b1;
    endtask

    task automatic noise_on();
        cpu_we = 1'b1;
        cpu_be = '1;
        cpu_wdata = $urandom;
        fill_start = 1'($urandom);
        evict_start = 1'($urandom);
    endtask

    task automatic clear_ctl();
        rd_req = 1'b0;
        cpu_we = 1'b0;
        fill_start = 1'b0;
        evict_start = 1'b0;
        fill_valid = 1'b0;
        evict_ready = 1'b0;
    endtask

    task automatic fill(int l, int rst_after, bit noise);
        int k, cyc;
        bit v, aborted;
        k = 0;
        cyc = 0;
        aborted = 0;
        idx = IW'(l);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        m_mode = 1;
        while (k < WORDS && cyc < 200 && !aborted) begin
            if (k == rst_after) begin
                iRST = 1'b1;
                rand_read();
                tick();
                iRST = 1'b0;
                m_mode = 0;
                clear_ctl();
                aborted = 1;
            end else begin
                v = (pat.size() > 0) ? pat.pop_front() : 1'($urandom);
                fill_valid = v;
                if (v && dq.size() > 0) fill_data = dq.pop_front();
                else fill_data = $urandom;
                if (noise) noise_on();
                rand_read();
                tick();
                clear_ctl();
                if (v) begin
                    m[l*WORDS+k] = fill_data;
                    k++;
                    if (k == WORDS) begin
                        m_mode = 0;
                        done_q.push_back(1);
                    end
                end
                cyc++;
            end
        end
        if (cyc >= 200) check("fill_timeout", k, WORDS);
        tick();
        check("fill_done_missing", done_q.size(), 0);
    endtask

    task automatic evict(int l, bit also_fill, bit also_cpu, bit noise);
        int n, cyc;
        bit r;
        n = 0;
        cyc = 0;
        idx = IW'(l);
        word_off = '0;
        evict_start = 1'b1;
        fill_start = also_fill;
        cpu_we = also_cpu;
        cpu_be = '1;
        cpu_wdata = ~m[l*WORDS];
        tick();
        clear_ctl();
        m_mode = 2;
        for (int w = 0; w < WORDS; w++)
            ev_q.push_back('{m[l*WORDS+w], w == WORDS - 1});
        while (n < WORDS && cyc < 200) begin
            r = (pat.size() > 0) ? pat.pop_front() : 1'($urandom);
            evict_ready = r;
            if (noise) noise_on();
            rand_read();
            tick();
            clear_ctl();
            if (r) begin
                n++;
                if (n == WORDS) m_mode = 0;
            end
            cyc++;
        end
        if (cyc >= 200) check("evict_timeout", n, WORDS);
        tick();
        check("evict_leftover", ev_q.size(), 0);
        ev_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        iRST = 1'b1;
        idx = '0;
        word_off = '0;
        cpu_be = '0;
        cpu_wdata = '0;
        fill_data = '0;
        clear_ctl();
        repeat (3) tick();
        iRST = 1'b0;
        mon_en = 1;
        check("rst_fill_done", fill_done, 0);
        check("rst_evict_last", evict_last, 0);
        check("rst_busy", busy, 0);

        for (int a = 0; a < NW; a++)
            cpu_write(a / WORDS, a % WORDS, '1, $urandom);

        cpu_write(3, 1, 4'b1111, 32'hDEADBEEF);
        cpu_write(3, 1, 4'b0010, 32'h0000AA00);
        idx = 3;
        word_off = 1;
        rd_q.push_back(32'hDEADAAEF);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        cpu_write(4, 2, 4'b0000, $urandom);
        cpu_read(4, 2);
        cpu_write(4, 3, 4'b1001, $urandom);
        cpu_read(4, 3);

        pat = '{1, 0, 1, 1, 0, 1};
        dq = '{32'h10, 32'h11, 32'h12, 32'h13};
        fill(7, -1, 0);
        read_line(7);

        pat = '{1, 0, 0, 1, 1, 0, 1};
        evict(7, 0, 0, 0);

        fill(9, -1, 1);
        read_line(2);
        read_line(9);

        fill(12, 2, 0);
        read_line(12);

        evict(5, 1, 0, 0);
        read_line(5);

        evict(6, 0, 1, 0);
        read_line(6);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: cpu_write($urandom_range(0, LINES - 1),
                             $urandom_range(0, WORDS - 1),
                             BW'($urandom), $urandom);
                1: cpu_read($urandom_range(0, LINES - 1),
                            $urandom_range(0, WORDS - 1));
                2: fill($urandom_range(0, LINES - 1), -1, 1'($urandom));
                default: evict($urandom_range(0, LINES - 1),
                               1'($urandom), 1'($urandom), 1'($urandom));
            endcase
        end

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
